// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one registered compare/check unit among four requesters
// Grants one request per IDLE cycle, evaluates it in EXEC, holds the result in RESP until drained.
module cmp_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  input  logic [3:0]         req_pbit,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic               rsp_gt,
  output logic               rsp_lt,
  output logic               rsp_eq,
  output logic               rsp_zero,
  output logic               rsp_perr,
  output logic               rsp_uov,
  output logic               rsp_sov,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic [7:0]         err_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               pbit_q, pbit_d;
  logic [1:0]         id_q, id_d;
  logic [1:0]         rsp_id_q, rsp_id_d;
  logic               rsp_gt_q, rsp_gt_d, rsp_lt_q, rsp_lt_d, rsp_eq_q, rsp_eq_d;
  logic               rsp_zero_q, rsp_zero_d, rsp_perr_q, rsp_perr_d;
  logic               rsp_uov_q, rsp_uov_d, rsp_sov_q, rsp_sov_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               grant_vld;
  logic [1:0]         grant_idx;
  logic [1:0]         scan_idx;
  logic [WIDTH:0]     sum_ext;

  // Scan from ptr+4 down to ptr+1 so the nearest requester after ptr wins last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign req_ready = (state_q == IDLE && grant_vld && !rst) ? (4'b0001 << grant_idx) : 4'b0000;

  assign sum_ext = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    pbit_d      = pbit_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_gt_d    = rsp_gt_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_eq_d    = rsp_eq_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_perr_d  = rsp_perr_q;
    rsp_uov_d   = rsp_uov_q;
    rsp_sov_d   = rsp_sov_q;
    rsp_sum_d   = rsp_sum_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          a_d     = req_a[grant_idx*WIDTH +: WIDTH];
          b_d     = req_b[grant_idx*WIDTH +: WIDTH];
          pbit_d  = req_pbit[grant_idx];
          id_d    = grant_idx;
          ptr_d   = grant_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d   = id_q;
        rsp_gt_d   = a_q > b_q;
        rsp_lt_d   = a_q < b_q;
        rsp_eq_d   = a_q == b_q;
        rsp_zero_d = a_q == '0;
        rsp_perr_d = pbit_q ^ (^a_q);
        rsp_uov_d  = sum_ext[WIDTH];
        rsp_sum_d  = sum_ext[WIDTH-1:0];
        rsp_sov_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (rsp_perr_q && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd3;
      a_q         <= '0;
      b_q         <= '0;
      pbit_q      <= 1'b0;
      id_q        <= 2'd0;
      rsp_id_q    <= 2'd0;
      rsp_gt_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_perr_q  <= 1'b0;
      rsp_uov_q   <= 1'b0;
      rsp_sov_q   <= 1'b0;
      rsp_sum_q   <= '0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pbit_q      <= pbit_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_gt_q    <= rsp_gt_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_eq_q    <= rsp_eq_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_perr_q  <= rsp_perr_d;
      rsp_uov_q   <= rsp_uov_d;
      rsp_sov_q   <= rsp_sov_d;
      rsp_sum_q   <= rsp_sum_d;
      err_count_q <= err_count_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = rsp_gt_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_perr  = rsp_perr_q;
  assign rsp_uov   = rsp_uov_q;
  assign rsp_sov   = rsp_sov_q;
  assign rsp_sum   = rsp_sum_q;
  assign err_count = err_count_q;

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares one registered compare/check unit among four requesters. The unit covers magnitude compare, zero detect, parity check and add-overflow detect. It sits between the operand producers and a single result consumer. Producers use a valid/ready handshake; the consumer drains one-deep buffered results with its own valid/ready. It also keeps a saturating count of parity errors for status readback.

## Interface
- WIDTH, 8, operand width in bits (minimum 2)
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  per-requester request valid
- req_a  input  4*WIDTH  operand A; requester i uses [i*WIDTH +: WIDTH]
- req_b  input  4*WIDTH  operand B; same packing as req_a
- req_pbit  input  4  per-requester even-parity bit accompanying A
- req_ready  output  4  one-hot grant pulse; the request is consumed in a cycle where req_valid[i] and req_ready[i] are both high
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  2  index of the requester that owns the result
- rsp_gt, rsp_lt, rsp_eq  output  1 each  unsigned A>B, A<B, A==B; exactly one is set while rsp_valid=1
- rsp_zero  output  1  A == 0
- rsp_perr  output  1  req_pbit != ^A
- rsp_uov  output  1  carry out of the unsigned sum A+B
- rsp_sov  output  1  two's-complement overflow of A+B
- rsp_sum  output  WIDTH  (A+B) mod 2^WIDTH
- err_count  output  8  saturating count of responses with rsp_perr=1
- busy  output  1  high whenever state != IDLE

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any req_valid is high, assert req_ready for the round-robin winner (combinational from state, req_valid and the pointer).
  - Latch that requester's A, B, pbit and id into operand registers.
  - Set ptr to the winner id and go to EXEC.
  - If no req_valid is high, stay in IDLE with req_ready=0.
- **Round-robin**
  - Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - ptr resets to 3, so requester 0 wins first after reset.
- **EXEC**
  - The combinational compare/check logic evaluates the operand registers.
  - All rsp_* fields load into the result register. Go to RESP.
- **RESP**
  - rsp_valid=1 and all rsp_* fields are held stable until rsp_ready=1.
  - On the handshake: go to IDLE. If rsp_perr=1 and err_count<255, increment err_count.
- **Arithmetic**
  - sum = A+B computed at WIDTH+1 bits. uov = bit WIDTH. rsp_sum = low WIDTH bits.
  - sov = (A[MSB]==B[MSB]) && (rsp_sum[MSB]!=A[MSB]).
  - Compares are unsigned.
- **Requester rules**
  - A requester holds A, B and pbit stable while valid and not granted.
  - Dropping valid before grant is legal; that request is simply not served.
- req_ready is never asserted outside IDLE. At most one bit of req_ready is high in any cycle.

## Timing
- **Reset values:** state=IDLE, ptr=3, req_ready=0, rsp_valid=0, all rsp_* fields=0, rsp_id=0, err_count=0, busy=0.
- **Latency:** grant in cycle T, EXEC in T+1, rsp_valid=1 in T+2.
- **Throughput:**
  - With rsp_ready held high, the next grant is possible in T+3, giving one operation per 3 cycles.
  - Back-pressure stalls in RESP indefinitely. No requests are accepted while stalled.
- **Simultaneous valids:** only the round-robin winner is granted. Losers keep valid asserted and are served in later IDLE cycles in rotation order.
- **err_count saturation:** at 255 it holds; further parity errors are ignored.
- **err_count update timing:** updates on the rsp handshake edge only, never during a stall.
- **Reset mid-operation:** an in-flight request (EXEC or RESP) is discarded with no response. All outputs return to reset values on the cycle after rst is sampled high.
- **Reset priority:** rst overrides all other inputs in the same cycle.

## Test plan
- Reset, then req_valid=4'b0001 with A=10, B=20, pbit=0 -> req_ready=0001 in the first cycle; 2 cycles later rsp_valid=1 with rsp_id=0, lt=1, sum=30, perr=0 (^10=0), uov=0, sov=0.
- Requester 2 sends A=200, B=100 -> gt=1, sum=44, uov=1, sov=0. Requester 1 sends A=100, B=50 -> sum=150, sov=1, uov=0. Requester 3 sends A=120, B=120 -> eq=1, sum=240, sov=1, uov=0.
- Requester 0 sends A=0, B=5, pbit=1 -> zero=1, lt=1, perr=1, and err_count increments to 1 on the handshake only.
- req_valid=1111 held continuously with rsp_ready=1 -> grant order 0,1,2,3,0 on every third cycle; no requester is granted twice before all others have been granted.
- rsp_ready=0 for 10 cycles after a result -> rsp fields stay stable, busy=1, no req_ready pulses, err_count unchanged; releasing rsp_ready completes exactly one response.
- Assert rst during EXEC -> no rsp_valid afterwards and all outputs read their reset values. Separately, 260 perr responses -> err_count ends at 255.
